// File: rtl/sopc_pkg.sv
// Shared definitions for the SoPC shared-RAM arbiter: FSM encoding and
// default bus widths.
package sopc_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/sopc_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the shared-RAM arbiter.
// Handshake: reqN_i is held high for a whole tenure; every cycle with
// reqN_i & gntN_o is one beat, and ackN_o pulses exactly one cycle later.
interface sopc_ram_arbiter_if
    import sopc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0_i;
    logic              we0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [DATA_W-1:0] wdata0_i;
    logic              gnt0_o;
    logic              ack0_o;
    logic [DATA_W-1:0] rdata0_o;

    logic              req1_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              gnt1_o;
    logic              ack1_o;
    logic [DATA_W-1:0] rdata1_o;

    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        input  req0_i, we0_i, addr0_i, wdata0_i,
        input  req1_i, we1_i, addr1_i, wdata1_i,
        input  ram_rdata_i,
        output gnt0_o, ack0_o, rdata0_o,
        output gnt1_o, ack1_o, rdata1_o,
        output ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output req0_i, we0_i, addr0_i, wdata0_i,
        output req1_i, we1_i, addr1_i, wdata1_i,
        output ram_rdata_i,
        input  gnt0_o, ack0_o, rdata0_o,
        input  gnt1_o, ack1_o, rdata1_o,
        input  ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the last-owner register doubles as the
// current tenure owner for the arbiter.
module rr_arb2
    import sopc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_load,
    output logic       o_pick,
    output logic       o_last
);
    logic r_last;

    // Reset value 1 makes requester 0 win the first tie.
    assign o_pick = (&i_req) ? ~r_last : i_req[1];
    assign o_last = r_last;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_load) begin
            r_last <= o_pick;
        end
    end
endmodule

// File: rtl/sopc_ram_arbiter.sv
// Arbitrates the host loader and vision DMA onto the shared RAM port while
// stalling the OpenRISC core for the duration of any external tenure.
module sopc_ram_arbiter
    import sopc_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SETTLE    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    sopc_ram_arbiter_if.slave bus,
    output logic              cpu_stall_o,
    output state_t            dbg_state_o
);
    state_t            r_state;
    logic [3:0]        r_settle_cnt;
    logic [7:0]        r_beat_cnt;
    logic              r_gnt0, r_gnt1, r_ack0, r_ack1, r_stall;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [1:0]        w_req;
    logic              w_pick, w_owner, w_load;
    logic              w_beat0, w_beat1, w_beat, w_burst_last;
    logic              w_owner_req, w_other_req, w_owner_we;
    logic [ADDR_W-1:0] w_owner_addr;
    logic [DATA_W-1:0] w_owner_wdata;

    assign w_req  = {bus.req1_i, bus.req0_i};
    assign w_load = ((r_state == ST_IDLE) || (r_state == ST_DRAIN)) && (|w_req);

    rr_arb2 u_rr (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .i_req  (w_req),
        .i_load (w_load),
        .o_pick (w_pick),
        .o_last (w_owner)
    );

    assign w_owner_req   = w_owner ? bus.req1_i   : bus.req0_i;
    assign w_other_req   = w_owner ? bus.req0_i   : bus.req1_i;
    assign w_owner_we    = w_owner ? bus.we1_i    : bus.we0_i;
    assign w_owner_addr  = w_owner ? bus.addr1_i  : bus.addr0_i;
    assign w_owner_wdata = w_owner ? bus.wdata1_i : bus.wdata0_i;

    assign w_beat0      = bus.req0_i & r_gnt0;
    assign w_beat1      = bus.req1_i & r_gnt1;
    assign w_beat       = w_beat0 | w_beat1;
    assign w_burst_last = w_beat && (r_beat_cnt == 8'(MAX_BURST - 1));

    // RAM bus is combinational during a beat and parks on the last beat's values.
    assign bus.ram_we_o    = w_beat & w_owner_we;
    assign bus.ram_addr_o  = w_beat ? w_owner_addr  : r_addr;
    assign bus.ram_wdata_o = w_beat ? w_owner_wdata : r_wdata;

    assign bus.gnt0_o   = r_gnt0;
    assign bus.gnt1_o   = r_gnt1;
    assign bus.ack0_o   = r_ack0;
    assign bus.ack1_o   = r_ack1;
    assign bus.rdata0_o = bus.ram_rdata_i;
    assign bus.rdata1_o = bus.ram_rdata_i;
    assign cpu_stall_o  = r_stall;
    assign dbg_state_o  = r_state;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
            r_beat_cnt   <= 8'd0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_stall      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_ack0 <= w_beat0;
            r_ack1 <= w_beat1;
            if (w_beat) begin
                r_addr  <= w_owner_addr;
                r_wdata <= w_owner_wdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= 4'd0;
                        r_stall      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 4'(SETTLE - 1)) begin
                        if (|w_req) begin
                            r_state    <= ST_GRANT;
                            r_beat_cnt <= 8'd0;
                            r_gnt0     <= ~w_owner;
                            r_gnt1     <= w_owner;
                        end else begin
                            r_state <= ST_IDLE;
                            r_stall <= 1'b0;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || (w_burst_last && w_other_req)) begin
                        r_state <= ST_DRAIN;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                    end else if (w_beat) begin
                        // With nobody waiting the counter wraps and the tenure goes on.
                        r_beat_cnt <= w_burst_last ? 8'd0 : r_beat_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (|w_req) begin
                        r_state    <= ST_GRANT;
                        r_beat_cnt <= 8'd0;
                        r_gnt0     <= ~w_pick;
                        r_gnt1     <= w_pick;
                    end else begin
                        r_state <= ST_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sopc_ram_arbiter.md
SOPC_RAM_ARBITER -- requirements
Module: sopc_ram_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-low reset: clk_i and rst_n (sampled on rising clk_i only).
REQ-002 Parameter ADDR_W, default 16: shared RAM word-address width.
REQ-003 Parameter DATA_W, default 32: RAM data width.
REQ-004 Parameter SETTLE, default 2: cycles the CPU is stalled before the first grant (1..15).
REQ-005 Parameter MAX_BURST, default 16: beats per tenure before forced rotation (2..255).
REQ-006 clk_i  input  1  system clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 reqN_i  input  1  requester N (N=0 host loader, N=1 vision DMA) wants the RAM port; held high for its whole tenure.
REQ-009 weN_i  input  1  requester N beat is a write (1) or a read (0).
REQ-010 addrN_i  input  ADDR_W  requester N beat address.
REQ-011 wdataN_i  input  DATA_W  requester N write data.
REQ-012 gntN_o  output  1  requester N owns the port; beat = reqN_i & gntN_o.
REQ-013 ackN_o  output  1  one-cycle pulse, one cycle after each beat of requester N.
REQ-014 rdataN_o  output  DATA_W  read data, valid while ackN_o is high for a read beat.
REQ-015 ram_we_o  output  1  shared RAM write enable (drives RAM_WE).
REQ-016 ram_addr_o  output  ADDR_W  shared RAM address (drives RAM_ADDR).
REQ-017 ram_wdata_o  output  DATA_W  shared RAM write data (drives RAM_DATA_I).
REQ-018 ram_rdata_i  input  DATA_W  shared RAM read data (from RAM_DATA_O), valid one cycle after the address.
REQ-019 cpu_stall_o  output  1  stalls the OpenRISC core (drives openRISC_STALL).

Function
REQ-020 FSM states SHALL be IDLE, SETTLE, GRANT, DRAIN; state, gntN_o, ackN_o and cpu_stall_o SHALL all be registered.
REQ-021 IDLE: cpu_stall_o=0; if any reqN_i is high, go to SETTLE and select the owner by round-robin.
REQ-022 Round-robin: the requester that did not own the last tenure wins a tie; after reset, requester 0 wins a tie.
REQ-023 SETTLE: cpu_stall_o=1; count SETTLE cycles, then go to GRANT; the owner is frozen on SETTLE entry.
REQ-024 GRANT: gnt of the owner =1 and other gnt =0; every cycle with owner req high is a beat.
REQ-025 In GRANT, ram_we_o/ram_addr_o/ram_wdata_o SHALL combinationally follow the owner's weN_i/addrN_i/wdataN_i during a beat.
REQ-026 Outside a beat, ram_we_o=0 and ram_addr_o/ram_wdata_o SHALL hold their last values.
REQ-027 ackN_o SHALL pulse in the cycle after each beat of N; for a read beat, rdataN_o=ram_rdata_i in that cycle.
REQ-028 Beat counter (8-bit) SHALL reset on GRANT entry and increment per beat.
REQ-029 Tenure end: owner req low in GRANT, or a beat with count==MAX_BURST-1 while the other req is high; next state is DRAIN.
REQ-030 If the count reaches MAX_BURST-1 with the other requester idle, the counter SHALL wrap to 0 and the tenure SHALL continue.
REQ-031 DRAIN (1 cycle): both gnt=0, cpu_stall_o=1, the pending ack is issued.
REQ-032 From DRAIN: if any req is high, go directly to GRANT with the round-robin winner and without SETTLE; otherwise go to IDLE.
REQ-033 cpu_stall_o SHALL be 1 in SETTLE, GRANT and DRAIN, and SHALL fall on the edge entering IDLE.
REQ-034 A requester dropping req while not granted SHALL have no effect; if no req remains at the end of SETTLE, go to IDLE.

Reset
REQ-035 When rst_n=0 at an edge: state=IDLE, gnt=0, ack=0, cpu_stall_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, counters=0, RR pointer favours requester 0.
REQ-036 A reset during GRANT SHALL abort the tenure; no ack SHALL be issued for a beat in the reset cycle.

Structure
REQ-037 The FSM state encoding and the ADDR_W/DATA_W defaults SHALL live in the shared package sopc_pkg.
REQ-038 The block SHALL contain one sub-module, rr_arb2, a two-input round-robin picker with a last-owner register.

Verification
REQ-039 SETTLE=2. req0 goes high at cycle 0 → cpu_stall_o=1 at cycle 1, gnt0_o=1 at cycle 3, ram_we_o follows we0_i.
REQ-040 req0 writes 0xDEADBEEF to address 0x0010, then reads 0x0010 → ack0_o one cycle after each beat; rdata0_o=0xDEADBEEF on the read ack.
REQ-041 req0 and req1 rise in the same cycle after reset → requester 0 is granted first; after req0 drops, DRAIN lasts 1 cycle, then gnt1_o=1 with no SETTLE and cpu_stall_o never drops.
REQ-042 MAX_BURST=4, req0 streaming, req1 raised → gnt0_o falls after exactly 4 beats; req1 is granted; req0 is re-granted afterwards.
REQ-043 MAX_BURST=4, only req0 streaming 10 beats → gnt0_o stays high throughout and 10 acks are issued.
REQ-044 rst_n=0 asserted mid-burst → at the next edge all outputs are 0 and state is IDLE; with req held, the following SETTLE restarts cleanly.
